// File: rtl/exe_stage_pkg.sv
// Shared pipeline definitions for the execute stage: operation/selector codes,
// bus widths, divider states and a leading-zero counting helper.
package exe_stage_pkg;

    localparam int          RegBus    = 32;
    localparam int          AluOpBus  = 8;
    localparam int          AluSelBus = 3;
    localparam logic [31:0] ZeroWord  = 32'h0000_0000;

    localparam logic [7:0] EXE_NOP_OP   = 8'b0000_0000;
    localparam logic [7:0] EXE_AND_OP   = 8'b0010_0100;
    localparam logic [7:0] EXE_OR_OP    = 8'b0010_0101;
    localparam logic [7:0] EXE_XOR_OP   = 8'b0010_0110;
    localparam logic [7:0] EXE_NOR_OP   = 8'b0010_0111;
    localparam logic [7:0] EXE_SLL_OP   = 8'b0111_1100;
    localparam logic [7:0] EXE_SRL_OP   = 8'b0000_0010;
    localparam logic [7:0] EXE_SRA_OP   = 8'b0000_0011;
    localparam logic [7:0] EXE_MOVZ_OP  = 8'b0000_1010;
    localparam logic [7:0] EXE_MOVN_OP  = 8'b0000_1011;
    localparam logic [7:0] EXE_MFHI_OP  = 8'b0001_0000;
    localparam logic [7:0] EXE_MTHI_OP  = 8'b0001_0001;
    localparam logic [7:0] EXE_MFLO_OP  = 8'b0001_0010;
    localparam logic [7:0] EXE_MTLO_OP  = 8'b0001_0011;
    localparam logic [7:0] EXE_SLT_OP   = 8'b0010_1010;
    localparam logic [7:0] EXE_SLTU_OP  = 8'b0010_1011;
    localparam logic [7:0] EXE_ADD_OP   = 8'b0010_0000;
    localparam logic [7:0] EXE_ADDU_OP  = 8'b0010_0001;
    localparam logic [7:0] EXE_SUB_OP   = 8'b0010_0010;
    localparam logic [7:0] EXE_SUBU_OP  = 8'b0010_0011;
    localparam logic [7:0] EXE_ADDI_OP  = 8'b0101_0101;
    localparam logic [7:0] EXE_ADDIU_OP = 8'b0101_0110;
    localparam logic [7:0] EXE_CLZ_OP   = 8'b1011_0000;
    localparam logic [7:0] EXE_CLO_OP   = 8'b1011_0001;
    localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
    localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
    localparam logic [7:0] EXE_MUL_OP   = 8'b1010_1001;
    localparam logic [7:0] EXE_MADD_OP  = 8'b1010_0110;
    localparam logic [7:0] EXE_MADDU_OP = 8'b1010_1000;
    localparam logic [7:0] EXE_MSUB_OP  = 8'b1010_1010;
    localparam logic [7:0] EXE_MSUBU_OP = 8'b1010_1011;
    localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;

    localparam logic [2:0] EXE_RES_NOP         = 3'b000;
    localparam logic [2:0] EXE_RES_LOGIC       = 3'b001;
    localparam logic [2:0] EXE_RES_SHIFT       = 3'b010;
    localparam logic [2:0] EXE_RES_MOVE        = 3'b011;
    localparam logic [2:0] EXE_RES_ARITH       = 3'b100;
    localparam logic [2:0] EXE_RES_MUL         = 3'b101;
    localparam logic [2:0] EXE_RES_JUMP_BRANCH = 3'b110;

    typedef enum logic [1:0] {
        DIV_FREE    = 2'b00,
        DIV_BY_ZERO = 2'b01,
        DIV_ON      = 2'b10,
        DIV_END     = 2'b11
    } div_state_t;

    function automatic logic [31:0] count_lead_zeros(input logic [31:0] v);
        logic [31:0] n;
        logic        found;
        n     = '0;
        found = 1'b0;
        for (int i = 31; i >= 0; i--) begin
            if (!found) begin
                if (v[i]) found = 1'b1;
                else      n = n + 32'd1;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/exe_div.sv
// Radix-2 restoring divider: one quotient bit per cycle on operand magnitudes,
// signs restored in the DIV_END cycle, which is the only cycle with ready high.
module exe_div
    import exe_stage_pkg::*;
#(
    parameter int DIV_ITER = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        signed_div,
    input  logic [31:0] opdata1,
    input  logic [31:0] opdata2,
    input  logic        annul,
    output logic [63:0] result,
    output logic        ready
);

    localparam int CW = $clog2(DIV_ITER);

    div_state_t    state_q, state_d;
    logic [CW-1:0] iter_q;
    logic [31:0]   rem_q, quo_q, dvs_q;
    logic          quo_neg_q, rem_neg_q;

    logic [31:0] mag1, mag2;
    logic [32:0] trial, diff;
    logic        take;

    assign mag1  = (signed_div && opdata1[31]) ? (32'd0 - opdata1) : opdata1;
    assign mag2  = (signed_div && opdata2[31]) ? (32'd0 - opdata2) : opdata2;
    assign trial = {rem_q, quo_q[31]};
    assign diff  = trial - {1'b0, dvs_q};
    assign take  = ~diff[32];

    always_comb begin
        state_d = state_q;
        case (state_q)
            DIV_FREE: begin
                if (start) state_d = (opdata2 == 32'd0) ? DIV_BY_ZERO : DIV_ON;
            end
            DIV_BY_ZERO: state_d = DIV_END;
            DIV_ON: begin
                if (iter_q == CW'(DIV_ITER - 1)) state_d = DIV_END;
            end
            DIV_END: state_d = DIV_FREE;
            default: state_d = DIV_FREE;
        endcase
        if (annul) state_d = DIV_FREE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= DIV_FREE;
            iter_q    <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                DIV_FREE: begin
                    if (start && !annul) begin
                        iter_q    <= '0;
                        rem_q     <= '0;
                        quo_q     <= mag1;
                        dvs_q     <= mag2;
                        quo_neg_q <= signed_div && (opdata1[31] ^ opdata2[31]);
                        rem_neg_q <= signed_div && opdata1[31];
                    end
                end
                DIV_BY_ZERO: begin
                    rem_q     <= '0;
                    quo_q     <= '0;
                    quo_neg_q <= 1'b0;
                    rem_neg_q <= 1'b0;
                end
                DIV_ON: begin
                    rem_q  <= take ? diff[31:0] : trial[31:0];
                    quo_q  <= {quo_q[30:0], take};
                    iter_q <= iter_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Quotient is negative when operand signs differ; remainder follows the dividend.
    always_comb begin
        ready  = (state_q == DIV_END);
        result = '0;
        if (ready) begin
            result[31:0]  = quo_neg_q ? (32'd0 - quo_q) : quo_q;
            result[63:32] = rem_neg_q ? (32'd0 - rem_q) : rem_q;
        end
    end

endmodule

// File: rtl/exe_stage.sv
// MIPS32 execute stage: single-cycle ALU plus 2-cycle MADD/MSUB and iterative divider.
// Define EXE_OVF_TRAP_EN to add ovf_assert and suppress writes on signed ADD/SUB overflow.
module exe_stage
    import exe_stage_pkg::*;
#(
    parameter int DIV_ITER = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  ex_alu_op,
    input  logic [2:0]  ex_alu_sel,
    input  logic [31:0] ex_reg1,
    input  logic [31:0] ex_reg2,
    input  logic [4:0]  ex_w_add,
    input  logic        ex_w_reg,
    input  logic [31:0] ex_add_link,
    input  logic        ex_in_delayslot,
    input  logic [31:0] hi_i,
    input  logic [31:0] lo_i,
    input  logic        flush,
    output logic [31:0] exe_w_data,
    output logic [4:0]  exe_w_add,
    output logic        exe_w_reg,
    output logic        exe_w_hilo,
    output logic [31:0] exe_hi,
    output logic [31:0] exe_lo,
    output logic        exe_in_delayslot,
    output logic        stall_req
`ifdef EXE_OVF_TRAP_EN
    ,
    output logic        ovf_assert
`endif
);

    logic [31:0] logic_res, shift_res, arith_res, move_res;
    logic [31:0] b_eff, sum;
    logic        is_sub, mul_signed, madd_op, msub_op, div_op;
    logic [63:0] ext_a, ext_b, prod, madd_sum;
    logic [63:0] temp_q;
    logic [1:0]  cnt_q;
    logic [63:0] div_result;
    logic        div_ready;
`ifdef EXE_OVF_TRAP_EN
    logic        ovf;
`endif

    assign is_sub     = (ex_alu_op == EXE_SUB_OP) || (ex_alu_op == EXE_SUBU_OP);
    assign b_eff      = is_sub ? ~ex_reg2 : ex_reg2;
    assign sum        = ex_reg1 + b_eff + {31'd0, is_sub};
    assign mul_signed = (ex_alu_op == EXE_MULT_OP) || (ex_alu_op == EXE_MUL_OP) ||
                        (ex_alu_op == EXE_MADD_OP) || (ex_alu_op == EXE_MSUB_OP);
    assign msub_op    = (ex_alu_op == EXE_MSUB_OP) || (ex_alu_op == EXE_MSUBU_OP);
    assign madd_op    = msub_op || (ex_alu_op == EXE_MADD_OP) || (ex_alu_op == EXE_MADDU_OP);
    assign div_op     = (ex_alu_op == EXE_DIV_OP) || (ex_alu_op == EXE_DIVU_OP);

    // Low 64 bits of the extended product are correct for signed and unsigned alike.
    assign ext_a    = {{32{mul_signed & ex_reg1[31]}}, ex_reg1};
    assign ext_b    = {{32{mul_signed & ex_reg2[31]}}, ex_reg2};
    assign prod     = ext_a * ext_b;
    assign madd_sum = temp_q + {hi_i, lo_i};

`ifdef EXE_OVF_TRAP_EN
    assign ovf = ((ex_alu_op == EXE_ADD_OP) || (ex_alu_op == EXE_ADDI_OP) ||
                  (ex_alu_op == EXE_SUB_OP)) &&
                 (ex_reg1[31] == b_eff[31]) && (sum[31] != ex_reg1[31]);
`endif

    always_comb begin
        logic_res = ZeroWord;
        shift_res = ZeroWord;
        move_res  = ZeroWord;
        arith_res = ZeroWord;
        case (ex_alu_op)
            EXE_AND_OP:  logic_res = ex_reg1 & ex_reg2;
            EXE_OR_OP:   logic_res = ex_reg1 | ex_reg2;
            EXE_XOR_OP:  logic_res = ex_reg1 ^ ex_reg2;
            EXE_NOR_OP:  logic_res = ~(ex_reg1 | ex_reg2);
            EXE_SLL_OP:  shift_res = ex_reg2 << ex_reg1[4:0];
            EXE_SRL_OP:  shift_res = ex_reg2 >> ex_reg1[4:0];
            EXE_SRA_OP:  shift_res = 32'($signed(ex_reg2) >>> ex_reg1[4:0]);
            EXE_MOVZ_OP, EXE_MOVN_OP: move_res = ex_reg1;
            EXE_MFHI_OP: move_res = hi_i;
            EXE_MFLO_OP: move_res = lo_i;
            EXE_ADD_OP, EXE_ADDU_OP, EXE_ADDI_OP, EXE_ADDIU_OP,
            EXE_SUB_OP, EXE_SUBU_OP: arith_res = sum;
            EXE_SLT_OP:  arith_res = {31'd0, ($signed(ex_reg1) < $signed(ex_reg2))};
            EXE_SLTU_OP: arith_res = {31'd0, (ex_reg1 < ex_reg2)};
            EXE_CLZ_OP:  arith_res = count_lead_zeros(ex_reg1);
            EXE_CLO_OP:  arith_res = count_lead_zeros(~ex_reg1);
            default: ;
        endcase
    end

    // MADD/MSUB: first cycle latches the (possibly negated) product, second accumulates.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= 2'd0;
            temp_q <= '0;
        end else if (flush) begin
            cnt_q <= 2'd0;
        end else if (madd_op && cnt_q == 2'd0) begin
            temp_q <= msub_op ? (64'd0 - prod) : prod;
            cnt_q  <= 2'd1;
        end else begin
            cnt_q <= 2'd0;
        end
    end

    exe_div #(
        .DIV_ITER(DIV_ITER)
    ) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (div_op),
        .signed_div(ex_alu_op == EXE_DIV_OP),
        .opdata1   (ex_reg1),
        .opdata2   (ex_reg2),
        .annul     (flush),
        .result    (div_result),
        .ready     (div_ready)
    );

    always_comb begin
        exe_w_data       = ZeroWord;
        exe_w_add        = ex_w_add;
        exe_w_reg        = ex_w_reg;
        exe_w_hilo       = 1'b0;
        exe_hi           = ZeroWord;
        exe_lo           = ZeroWord;
        exe_in_delayslot = ex_in_delayslot;
        stall_req        = 1'b0;
`ifdef EXE_OVF_TRAP_EN
        ovf_assert       = 1'b0;
`endif
        case (ex_alu_sel)
            EXE_RES_LOGIC:       exe_w_data = logic_res;
            EXE_RES_SHIFT:       exe_w_data = shift_res;
            EXE_RES_MOVE:        exe_w_data = move_res;
            EXE_RES_ARITH:       exe_w_data = arith_res;
            EXE_RES_MUL:         exe_w_data = prod[31:0];
            EXE_RES_JUMP_BRANCH: exe_w_data = ex_add_link;
            default: ;
        endcase
        if ((ex_alu_op == EXE_MOVZ_OP && ex_reg2 != ZeroWord) ||
            (ex_alu_op == EXE_MOVN_OP && ex_reg2 == ZeroWord))
            exe_w_reg = 1'b0;
`ifdef EXE_OVF_TRAP_EN
        if (ovf) begin
            ovf_assert = 1'b1;
            exe_w_reg  = 1'b0;
        end
`endif
        case (ex_alu_op)
            EXE_MULT_OP, EXE_MULTU_OP: begin
                exe_w_hilo = 1'b1;
                {exe_hi, exe_lo} = prod;
            end
            EXE_MTHI_OP: begin
                exe_w_hilo = 1'b1;
                exe_hi     = ex_reg1;
                exe_lo     = lo_i;
            end
            EXE_MTLO_OP: begin
                exe_w_hilo = 1'b1;
                exe_hi     = hi_i;
                exe_lo     = ex_reg1;
            end
            EXE_MADD_OP, EXE_MADDU_OP, EXE_MSUB_OP, EXE_MSUBU_OP: begin
                if (cnt_q == 2'd1) begin
                    exe_w_hilo = 1'b1;
                    {exe_hi, exe_lo} = madd_sum;
                end else begin
                    stall_req = 1'b1;
                end
            end
            EXE_DIV_OP, EXE_DIVU_OP: begin
                stall_req = ~div_ready;
                if (div_ready) begin
                    exe_w_hilo = 1'b1;
                    {exe_hi, exe_lo} = div_result;
                end
            end
            default: ;
        endcase
        if (flush) begin
            stall_req  = 1'b0;
            exe_w_reg  = 1'b0;
            exe_w_hilo = 1'b0;
        end
        // Reset is asynchronous, so the outputs go quiet without waiting for an edge.
        if (!rst) begin
            exe_w_data       = ZeroWord;
            exe_w_add        = 5'd0;
            exe_w_reg        = 1'b0;
            exe_w_hilo       = 1'b0;
            exe_hi           = ZeroWord;
            exe_lo           = ZeroWord;
            exe_in_delayslot = 1'b0;
            stall_req        = 1'b0;
`ifdef EXE_OVF_TRAP_EN
            ovf_assert       = 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_exe_stage.sv
// Scoreboard bench for exe_stage: expectations queued at issue, compared when the stall drops.
module tb_exe_stage;
    import exe_stage_pkg::*;

    logic        clk;
    logic        rst;
    logic [7:0]  ex_alu_op;
    logic [2:0]  ex_alu_sel;
    logic [31:0] ex_reg1, ex_reg2, ex_add_link, hi_i, lo_i;
    logic [4:0]  ex_w_add;
    logic        ex_w_reg, ex_in_delayslot, flush;
    logic [31:0] exe_w_data, exe_hi, exe_lo;
    logic [4:0]  exe_w_add;
    logic        exe_w_reg, exe_w_hilo, exe_in_delayslot, stall_req;
`ifdef EXE_OVF_TRAP_EN
    logic        ovf_assert;
`endif

    int checks = 0;
    int errors = 0;
    int txn    = 0;

    typedef struct {
        logic [31:0] data;
        logic        wreg;
        logic        hilo;
        logic [31:0] hi;
        logic [31:0] lo;
        int          stalls;
        logic [4:0]  wadd;
        logic        dslot;
        logic        ovf;
    } exp_t;

    exp_t sb_q[$];

    exe_stage dut (
        .clk             (clk),
        .rst             (rst),
        .ex_alu_op       (ex_alu_op),
        .ex_alu_sel      (ex_alu_sel),
        .ex_reg1         (ex_reg1),
        .ex_reg2         (ex_reg2),
        .ex_w_add        (ex_w_add),
        .ex_w_reg        (ex_w_reg),
        .ex_add_link     (ex_add_link),
        .ex_in_delayslot (ex_in_delayslot),
        .hi_i            (hi_i),
        .lo_i            (lo_i),
        .flush           (flush),
        .exe_w_data      (exe_w_data),
        .exe_w_add       (exe_w_add),
        .exe_w_reg       (exe_w_reg),
        .exe_w_hilo      (exe_w_hilo),
        .exe_hi          (exe_hi),
        .exe_lo          (exe_lo),
        .exe_in_delayslot(exe_in_delayslot),
        .stall_req       (stall_req)
`ifdef EXE_OVF_TRAP_EN
        ,
        .ovf_assert      (ovf_assert)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic exp_t mkExp(input logic [31:0] data, input logic wreg, input logic hilo,
                                   input logic [31:0] hi, input logic [31:0] lo, input int stalls);
        exp_t e;
        e.data   = data;
        e.wreg   = wreg;
        e.hilo   = hilo;
        e.hi     = hi;
        e.lo     = lo;
        e.stalls = stalls;
        e.wadd   = '0;
        e.dslot  = 1'b0;
        e.ovf    = 1'b0;
        return e;
    endfunction

    task automatic driveNop();
        ex_alu_op  = EXE_NOP_OP;
        ex_alu_sel = EXE_RES_NOP;
        ex_reg1    = '0;
        ex_reg2    = '0;
        ex_w_reg   = 1'b0;
        ex_w_add   = '0;
        ex_in_delayslot = 1'b0;
    endtask

    task automatic applyStimulus(input logic [7:0] op, input logic [2:0] sel,
                                 input logic [31:0] r1, input logic [31:0] r2,
                                 input logic [31:0] hi, input logic [31:0] lo,
                                 input logic wr, input exp_t e);
        exp_t ee;
        txn++;
        ex_alu_op       = op;
        ex_alu_sel      = sel;
        ex_reg1         = r1;
        ex_reg2         = r2;
        hi_i            = hi;
        lo_i            = lo;
        ex_w_reg        = wr;
        ex_w_add        = 5'(txn);
        ex_in_delayslot = txn[0];
        ee       = e;
        ee.wadd  = 5'(txn);
        ee.dslot = txn[0];
        sb_q.push_back(ee);
    endtask

    task automatic collectResult(input string tag);
        int   stalls;
        exp_t e;
        stalls = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!stall_req) break;
            stalls++;
        end
        e = sb_q.pop_front();
        checkOutput({tag, ".stalls"}, 64'(stalls), 64'(e.stalls));
        checkOutput({tag, ".data"},   64'(exe_w_data), 64'(e.data));
        checkOutput({tag, ".wreg"},   64'(exe_w_reg),  64'(e.wreg));
        checkOutput({tag, ".hilo"},   64'(exe_w_hilo), 64'(e.hilo));
        checkOutput({tag, ".hi"},     64'(exe_hi),     64'(e.hi));
        checkOutput({tag, ".lo"},     64'(exe_lo),     64'(e.lo));
        checkOutput({tag, ".wadd"},   64'(exe_w_add),  64'(e.wadd));
        checkOutput({tag, ".dslot"},  64'(exe_in_delayslot), 64'(e.dslot));
`ifdef EXE_OVF_TRAP_EN
        checkOutput({tag, ".ovf"},    64'(ovf_assert), 64'(e.ovf));
`endif
        @(posedge clk);
        #1;
        driveNop();
    endtask

    task automatic runOp(input string tag, input logic [7:0] op, input logic [2:0] sel,
                         input logic [31:0] r1, input logic [31:0] r2,
                         input logic [31:0] hi, input logic [31:0] lo,
                         input logic wr, input exp_t e);
        applyStimulus(op, sel, r1, r2, hi, lo, wr, e);
        collectResult(tag);
    endtask

    initial begin
        exp_t        e;
        logic [31:0] a, b;

        rst         = 1'b0;
        flush       = 1'b0;
        ex_add_link = 32'h0040_0008;
        hi_i        = 32'h1111_1111;
        lo_i        = 32'h2222_2222;
        ex_alu_op   = EXE_AND_OP;
        ex_alu_sel  = EXE_RES_LOGIC;
        ex_reg1     = 32'hFFFF_FFFF;
        ex_reg2     = 32'hFFFF_FFFF;
        ex_w_reg    = 1'b1;
        ex_w_add    = 5'd9;
        ex_in_delayslot = 1'b1;
        #3;
        checkOutput("rst.data",  64'(exe_w_data), 64'd0);
        checkOutput("rst.wreg",  64'(exe_w_reg),  64'd0);
        checkOutput("rst.wadd",  64'(exe_w_add),  64'd0);
        checkOutput("rst.dslot", 64'(exe_in_delayslot), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        driveNop();
        rst = 1'b1;

        // Single-cycle operations
        runOp("and",  EXE_AND_OP, EXE_RES_LOGIC, 32'hF0F0_1234, 32'h0FF0_FFFF, 0, 0, 1,
              mkExp(32'h00F0_1234, 1, 0, 0, 0, 0));
        runOp("lui",  EXE_OR_OP, EXE_RES_LOGIC, 32'h0, 32'h1234_0000, 0, 0, 1,
              mkExp(32'h1234_0000, 1, 0, 0, 0, 0));
        runOp("nor",  EXE_NOR_OP, EXE_RES_LOGIC, 32'h0000_FFFF, 32'h00FF_0000, 0, 0, 1,
              mkExp(32'hFF00_0000, 1, 0, 0, 0, 0));
        runOp("sra",  EXE_SRA_OP, EXE_RES_SHIFT, 32'd4, 32'h8000_0010, 0, 0, 1,
              mkExp(32'hF800_0001, 1, 0, 0, 0, 0));
        runOp("sllv", EXE_SLL_OP, EXE_RES_SHIFT, 32'h23, 32'd1, 0, 0, 1,
              mkExp(32'd8, 1, 0, 0, 0, 0));
        runOp("slt",  EXE_SLT_OP, EXE_RES_ARITH, 32'hFFFF_FFFF, 32'd1, 0, 0, 1,
              mkExp(32'd1, 1, 0, 0, 0, 0));
        runOp("sltu", EXE_SLTU_OP, EXE_RES_ARITH, 32'hFFFF_FFFF, 32'd1, 0, 0, 1,
              mkExp(32'd0, 1, 0, 0, 0, 0));
        runOp("clz",  EXE_CLZ_OP, EXE_RES_ARITH, 32'h0001_0000, 32'd0, 0, 0, 1,
              mkExp(32'd15, 1, 0, 0, 0, 0));
        runOp("clo",  EXE_CLO_OP, EXE_RES_ARITH, 32'hFFF0_0000, 32'd0, 0, 0, 1,
              mkExp(32'd12, 1, 0, 0, 0, 0));
        runOp("movz", EXE_MOVZ_OP, EXE_RES_MOVE, 32'hCAFE_0001, 32'd5, 0, 0, 1,
              mkExp(32'hCAFE_0001, 0, 0, 0, 0, 0));
        runOp("movn", EXE_MOVN_OP, EXE_RES_MOVE, 32'hCAFE_0002, 32'd5, 0, 0, 1,
              mkExp(32'hCAFE_0002, 1, 0, 0, 0, 0));
        runOp("mfhi", EXE_MFHI_OP, EXE_RES_MOVE, 0, 0, 32'h1357_9BDF, 32'h2468_ACE0, 1,
              mkExp(32'h1357_9BDF, 1, 0, 0, 0, 0));
        runOp("mtlo", EXE_MTLO_OP, EXE_RES_NOP, 32'hAAAA_5555, 0, 32'h1111_1111, 32'h2222_2222, 0,
              mkExp(32'd0, 0, 1, 32'h1111_1111, 32'hAAAA_5555, 0));
        runOp("mult", EXE_MULT_OP, EXE_RES_NOP, 32'hFFFF_FFFE, 32'd3, 0, 0, 0,
              mkExp(32'd0, 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 0));
        runOp("multu", EXE_MULTU_OP, EXE_RES_NOP, 32'hFFFF_FFFE, 32'd3, 0, 0, 0,
              mkExp(32'd0, 0, 1, 32'h0000_0002, 32'hFFFF_FFFA, 0));
        runOp("mul",  EXE_MUL_OP, EXE_RES_MUL, 32'hFFFF_FFFE, 32'd3, 0, 0, 1,
              mkExp(32'hFFFF_FFFA, 1, 0, 0, 0, 0));
        runOp("jal",  EXE_NOP_OP, EXE_RES_JUMP_BRANCH, 0, 0, 0, 0, 1,
              mkExp(32'h0040_0008, 1, 0, 0, 0, 0));
        runOp("unk",  8'hFF, EXE_RES_NOP, 32'h1234, 32'h5678, 0, 0, 1,
              mkExp(32'd0, 1, 0, 0, 0, 0));

        e = mkExp(32'h8000_0000, 1, 0, 0, 0, 0);
`ifdef EXE_OVF_TRAP_EN
        e.wreg = 1'b0;
        e.ovf  = 1'b1;
`endif
        runOp("addovf", EXE_ADD_OP, EXE_RES_ARITH, 32'h7FFF_FFFF, 32'd1, 0, 0, 1, e);

        for (int i = 0; i < 6; i++) begin
            a = $urandom;
            b = $urandom;
            case (i % 3)
                0: runOp("rnd.addu", EXE_ADDU_OP, EXE_RES_ARITH, a, b, 0, 0, 1, mkExp(a + b, 1, 0, 0, 0, 0));
                1: runOp("rnd.subu", EXE_SUBU_OP, EXE_RES_ARITH, a, b, 0, 0, 1, mkExp(a - b, 1, 0, 0, 0, 0));
                default: runOp("rnd.xor", EXE_XOR_OP, EXE_RES_LOGIC, a, b, 0, 0, 1, mkExp(a ^ b, 1, 0, 0, 0, 0));
            endcase
        end

        // Multi-cycle accumulate
        runOp("madd", EXE_MADD_OP, EXE_RES_NOP, 32'd3, 32'd4, 32'd0, 32'hFFFF_FFF8, 0,
              mkExp(32'd0, 0, 1, 32'h0000_0001, 32'h0000_0004, 1));
        runOp("msub", EXE_MSUB_OP, EXE_RES_NOP, 32'd3, 32'd4, 32'd0, 32'd10, 0,
              mkExp(32'd0, 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1));

        // Divider
        runOp("div.neg7by2", EXE_DIV_OP, EXE_RES_NOP, 32'hFFFF_FFF9, 32'd2, 0, 0, 0,
              mkExp(32'd0, 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33));
        runOp("divu.zero", EXE_DIVU_OP, EXE_RES_NOP, 32'd1234, 32'd0, 0, 0, 0,
              mkExp(32'd0, 0, 1, 32'd0, 32'd0, 2));
        runOp("div.100byneg7", EXE_DIV_OP, EXE_RES_NOP, 32'd100, 32'hFFFF_FFF9, 0, 0, 0,
              mkExp(32'd0, 0, 1, 32'd2, 32'hFFFF_FFF2, 33));
        runOp("div.minbyneg1", EXE_DIV_OP, EXE_RES_NOP, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0,
              mkExp(32'd0, 0, 1, 32'd0, 32'h8000_0000, 33));

        // Flush in the sixth divide iteration abandons the divide
        ex_alu_op  = EXE_DIV_OP;
        ex_alu_sel = EXE_RES_NOP;
        ex_reg1    = 32'd1000;
        ex_reg2    = 32'd3;
        ex_w_reg   = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        flush = 1'b1;
        @(negedge clk);
        checkOutput("flush.stall", 64'(stall_req),  64'd0);
        checkOutput("flush.hilo",  64'(exe_w_hilo), 64'd0);
        checkOutput("flush.wreg",  64'(exe_w_reg),  64'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        driveNop();
        @(negedge clk);
        checkOutput("postflush.stall", 64'(stall_req),  64'd0);
        checkOutput("postflush.hilo",  64'(exe_w_hilo), 64'd0);
        @(posedge clk);
        #1;
        runOp("divu.afterflush", EXE_DIVU_OP, EXE_RES_NOP, 32'd100, 32'd7, 0, 0, 0,
              mkExp(32'd0, 0, 1, 32'd2, 32'd14, 33));

        // Reset around the tenth divide iteration
        ex_alu_op  = EXE_DIV_OP;
        ex_alu_sel = EXE_RES_NOP;
        ex_reg1    = 32'hFFFF_FFF9;
        ex_reg2    = 32'd2;
        ex_w_reg   = 1'b1;
        ex_w_add   = 5'd7;
        ex_in_delayslot = 1'b1;
        repeat (11) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("midrst.stall", 64'(stall_req),  64'd0);
        checkOutput("midrst.wreg",  64'(exe_w_reg),  64'd0);
        checkOutput("midrst.wadd",  64'(exe_w_add),  64'd0);
        checkOutput("midrst.hilo",  64'(exe_w_hilo), 64'd0);
        checkOutput("midrst.hilo_data", {exe_hi, exe_lo}, 64'd0);
        checkOutput("midrst.dslot", 64'(exe_in_delayslot), 64'd0);
        driveNop();
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        checkOutput("postrst.stall", 64'(stall_req),  64'd0);
        checkOutput("postrst.ready", 64'(exe_w_hilo), 64'd0);
        @(posedge clk);
        #1;
        runOp("div.afterrst", EXE_DIV_OP, EXE_RES_NOP, 32'hFFFF_FFF9, 32'd2, 0, 0, 0,
              mkExp(32'd0, 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
